inv_sbox_v2: RTL and testbench
==============================

Name: inv_sbox_v2

Overview:
- AES inverse S-box (InvSubBytes) for one byte, used in the decryption datapath of the AES accelerator.
- Maps any 8-bit input to its FIPS-197 inverse S-box value: inverse affine transform, then multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with 0 mapping to 0.
- Provides a zero-latency combinational output plus a one-cycle registered copy with a valid flag, for pipelined use.

Parameters:
- None.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset; clears the registered outputs only.
- in_byte  input  8  byte to substitute.
- in_valid  input  1  qualifies in_byte for the registered path.
- out_byte  output  8  combinational InvSBox(in_byte).
- out_byte_q  output  8  registered InvSBox of in_byte, captured on the clk edge where in_valid=1.
- out_valid_q  output  1  high for the cycle after in_byte was captured with in_valid=1.

Behaviour:
- out_byte is purely combinational from in_byte.
  - No dependence on clk, rst or in_valid.
  - Must be settled within half a clock period of an in_byte change.
- Function: out_byte = InvSBox(in_byte) per FIPS-197, for all 256 inputs. The result must be bit-exact with no exceptions.
- Required implementation structure is composite-field logic; a 256-entry ROM is not acceptable.
  - Step 1: map the input through a linear isomorphism from GF(2^8) to GF((2^4)^2). The AES inverse-affine transform, including its constant, is folded into this map: output bits 2, 3, 4 and 5 of the map are complemented.
  - Step 2: split the mapped value into g1 (bits 7:4) and g0 (bits 3:0).
  - Step 3: compute delta = g1*g0 ^ g0^2 ^ v*g1^2, with v = 4'hD.
  - Step 4: compute inv = delta^-1 in GF(2^4), with 0^-1 = 0.
  - Step 5: compute d1 = g1*inv and d0 = (g0^g1)*inv.
  - Step 6: output InvIso({d1,d0}), a linear inverse map with no constant terms.
- All GF(2^4) arithmetic uses the field polynomial x^4+x+1, i.e. reduction mask 4'b0011 on carry out of bit 3.
- GF(2^4) inversion is a 4-input combinational table or sum-of-products, with 0 mapping to 0.
- Registered path:
  - On rst=1, asynchronously: out_byte_q=8'h00 and out_valid_q=0.
  - On each rising clk edge with rst=0: out_valid_q <= in_valid.
  - On that edge, if in_valid=1: out_byte_q <= InvSBox(in_byte); otherwise out_byte_q holds its value.
  - Latency is 1 cycle; a new byte can be accepted every cycle, with no backpressure.
- Reset asserted mid-stream: both registered outputs clear immediately. The first valid output appears one cycle after the first in_valid following reset release.
- X on in_byte may propagate to out_byte. out_byte_q only captures values qualified by in_valid.

Test Plan:
- Exhaustive sweep: drive in_byte = 0..255 and check out_byte at a half-cycle offset against a reference InvSBox model. All 256 must match.
  - Spot values: 00->52, 01->09, 02->6A, 03->D5, 52->48, 63->00, 7C->01, FF->7D.
- Pipelined stream: in_valid=1 for 4 cycles with bytes 63, 7C, 00, FF. Expect out_byte_q = 00, 01, 52, 7D on consecutive cycles, each one cycle later, with out_valid_q=1 throughout.
- Gaps: in_valid pattern 1,0,1 with bytes 01, AA, 02. Expect out_valid_q = 1, 0, 1 and out_byte_q = 09, 09 (held), 6A.
- Async reset: assert rst between clock edges while out_valid_q=1. Expect out_byte_q=00 and out_valid_q=0 immediately, not at the next edge. out_byte must keep tracking in_byte during reset.
- Round trip: feed each InvSBox output through a reference forward S-box model. Must recover the original input for all 256 values, confirming a bijection.

Source files
------------

// File: rtl/inv_sbox_v2.sv
// AES inverse S-box over the composite field GF((2^4)^2), y^2 = y + 4'hD.
// Combinational out_byte plus a one-cycle registered copy with valid flag.
module inv_sbox_v2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic [7:0] out_byte,
    output logic [7:0] out_byte_q,
    output logic       out_valid_q
);

    localparam logic [3:0] V = 4'hD;

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] s;
        p = 4'h0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h0: r = 4'h0;
            4'h1: r = 4'h1;
            4'h2: r = 4'h9;
            4'h3: r = 4'hE;
            4'h4: r = 4'hD;
            4'h5: r = 4'hB;
            4'h6: r = 4'h7;
            4'h7: r = 4'h6;
            4'h8: r = 4'hF;
            4'h9: r = 4'h2;
            4'hA: r = 4'hC;
            4'hB: r = 4'h5;
            4'hC: r = 4'hA;
            4'hD: r = 4'h4;
            4'hE: r = 4'h3;
            default: r = 4'h8;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        logic [3:0] hi;
        logic [3:0] lo;
        hh = gf4_mul(a[7:4], b[7:4]);
        hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
        lo = gf4_mul(a[3:0], b[3:0]) ^ gf4_mul(V, hh);
        return {hi, lo};
    endfunction

    // Column j of a packed 8x8 GF(2) matrix lives in m[8*j +: 8].
    function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (x[j]) r = r ^ m[8*j +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] pow_cols(input logic [7:0] b);
        logic [63:0] m;
        logic [7:0]  p;
        m = 64'h0;
        p = 8'h01;
        for (int j = 0; j < 8; j++) begin
            m[8*j +: 8] = p;
            p = gf8_mul(p, b);
        end
        return m;
    endfunction

    function automatic logic is_aes_root(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p = 8'h01;
        acc = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            p = gf8_mul(p, b);
            if (e == 1 || e == 3 || e == 4 || e == 8) acc = acc ^ p;
        end
        return acc == 8'h00;
    endfunction

    // Of the eight conjugate roots, prefer the one whose folded constant is 8'h3C.
    function automatic logic [63:0] find_iso();
        logic [63:0] any_m;
        logic [63:0] pref_m;
        logic        have_any;
        logic        have_pref;
        any_m = 64'h0;
        pref_m = 64'h0;
        have_any = 1'b0;
        have_pref = 1'b0;
        for (int b = 2; b < 256; b++) begin
            if (is_aes_root(8'(b))) begin
                if (!have_any) begin
                    any_m = pow_cols(8'(b));
                    have_any = 1'b1;
                end
                if (!have_pref && mat_apply(pow_cols(8'(b)), 8'h05) == 8'h3C) begin
                    pref_m = pow_cols(8'(b));
                    have_pref = 1'b1;
                end
            end
        end
        return have_pref ? pref_m : any_m;
    endfunction

    function automatic logic [7:0] inv_affine_lin(input logic [7:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]};
    endfunction

    function automatic logic [63:0] fold_map(input logic [63:0] iso);
        logic [63:0] m;
        m = 64'h0;
        for (int j = 0; j < 8; j++) begin
            m[8*j +: 8] = mat_apply(iso, inv_affine_lin(8'h01 << j));
        end
        return m;
    endfunction

    function automatic logic [63:0] inv_cols(input logic [63:0] iso);
        logic [63:0] m;
        logic [7:0]  y;
        m = 64'h0;
        for (int a = 0; a < 256; a++) begin
            y = mat_apply(iso, 8'(a));
            for (int k = 0; k < 8; k++) begin
                if (y == (8'h01 << k)) m[8*k +: 8] = 8'(a);
            end
        end
        return m;
    endfunction

    localparam logic [63:0] ISO   = find_iso();
    localparam logic [63:0] M_IN  = fold_map(ISO);
    localparam logic [7:0]  ISO_C = mat_apply(ISO, 8'h05);
    localparam logic [63:0] M_OUT = inv_cols(ISO);

    logic [7:0] map_s;
    logic [3:0] g1;
    logic [3:0] g0;
    logic [3:0] delta;
    logic [3:0] dinv;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [7:0] out_byte_d;

    always_comb begin
        map_s = mat_apply(M_IN, in_byte) ^ ISO_C;
        g1    = map_s[7:4];
        g0    = map_s[3:0];
        delta = gf4_mul(g1, g0) ^ gf4_mul(g0, g0) ^ gf4_mul(V, gf4_mul(g1, g1));
        dinv  = gf4_inv(delta);
        d1    = gf4_mul(g1, dinv);
        d0    = gf4_mul(g0 ^ g1, dinv);
    end

    assign out_byte = mat_apply(M_OUT, {d1, d0});

    always_comb begin
        out_byte_d = out_byte_q;
        if (in_valid) out_byte_d = out_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_byte_q  <= out_byte_d;
            out_valid_q <= in_valid;
        end
    end

endmodule

// File: tb/tb_inv_sbox_v2.sv
// Bench for inv_sbox_v2: table spot values, full sweep, pipeline sequences,
// async reset and a randomized stream against a GF(2^8) reference model.
module tb_inv_sbox_v2;

    logic       clk;
    logic       rst;
    logic [7:0] in_byte;
    logic       in_valid;
    logic [7:0] out_byte;
    logic [7:0] out_byte_q;
    logic       out_valid_q;

    int tests;
    int fails;

    logic [7:0] inv8[256];
    logic [7:0] inv_ref[256];
    logic [7:0] fwd_ref[256];

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t spot[8];

    inv_sbox_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .out_byte    (out_byte),
        .out_byte_q  (out_byte_q),
        .out_valid_q (out_valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) r = 8'(b);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] y;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        end
        return y;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] y;
        c = 8'h05;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ c[i];
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v);
        in_byte  = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pipe_in[4];
    logic [7:0] pipe_exp[4];
    logic [7:0] rb;
    logic       rv;
    logic       exp_v;
    logic [7:0] exp_b;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        in_byte = 8'h00;
        in_valid = 1'b0;

        for (int a = 0; a < 256; a++) inv8[a] = ginv(8'(a));
        for (int a = 0; a < 256; a++) begin
            inv_ref[a] = inv8[inv_affine(8'(a))];
            fwd_ref[a] = affine(inv8[a]);
        end

        spot[0] = '{8'h00, 8'h52};
        spot[1] = '{8'h01, 8'h09};
        spot[2] = '{8'h02, 8'h6A};
        spot[3] = '{8'h03, 8'hD5};
        spot[4] = '{8'h52, 8'h48};
        spot[5] = '{8'h63, 8'h00};
        spot[6] = '{8'h7C, 8'h01};
        spot[7] = '{8'hFF, 8'h7D};

        #2;
        check("reset_byte_q", 32'(out_byte_q), 32'h00);
        check("reset_valid_q", 32'(out_valid_q), 32'h0);

        for (int k = 0; k < 8; k++) begin
            in_byte = spot[k].din;
            #4;
            check("spot", 32'(out_byte), 32'(spot[k].dout));
        end

        for (int i = 0; i < 256; i++) begin
            in_byte = 8'(i);
            #4;
            check("sweep", 32'(out_byte), 32'(inv_ref[i]));
            check("roundtrip", 32'(fwd_ref[out_byte]), 32'(i));
        end

        @(negedge clk);
        rst = 1'b0;

        pipe_in  = '{8'h63, 8'h7C, 8'h00, 8'hFF};
        pipe_exp = '{8'h00, 8'h01, 8'h52, 8'h7D};
        for (int k = 0; k < 4; k++) begin
            step(pipe_in[k], 1'b1);
            check("pipe_valid", 32'(out_valid_q), 32'h1);
            check("pipe_byte", 32'(out_byte_q), 32'(pipe_exp[k]));
        end

        step(8'h01, 1'b1);
        check("gap_valid0", 32'(out_valid_q), 32'h1);
        check("gap_byte0", 32'(out_byte_q), 32'h09);
        step(8'hAA, 1'b0);
        check("gap_valid1", 32'(out_valid_q), 32'h0);
        check("gap_byte1", 32'(out_byte_q), 32'h09);
        step(8'h02, 1'b1);
        check("gap_valid2", 32'(out_valid_q), 32'h1);
        check("gap_byte2", 32'(out_byte_q), 32'h6A);

        #3;
        rst = 1'b1;
        #1;
        check("arst_byte_q", 32'(out_byte_q), 32'h00);
        check("arst_valid_q", 32'(out_valid_q), 32'h0);
        in_byte = 8'h52;
        #1;
        check("arst_comb", 32'(out_byte), 32'h48);
        @(posedge clk);
        #1;
        check("arst_hold_valid", 32'(out_valid_q), 32'h0);
        check("arst_hold_byte", 32'(out_byte_q), 32'h00);
        rst = 1'b0;
        step(8'h11, 1'b0);
        check("post_rst_valid", 32'(out_valid_q), 32'h0);
        check("post_rst_byte", 32'(out_byte_q), 32'h00);
        step(8'hFF, 1'b1);
        check("first_valid", 32'(out_valid_q), 32'h1);
        check("first_byte", 32'(out_byte_q), 32'h7D);

        exp_v = 1'b1;
        exp_b = 8'h7D;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rnd_arst_valid", 32'(out_valid_q), 32'h0);
                check("rnd_arst_byte", 32'(out_byte_q), 32'h00);
                rst = 1'b0;
                exp_v = 1'b0;
                exp_b = 8'h00;
            end
            rb = 8'($urandom);
            rv = 1'($urandom_range(0, 1));
            in_byte = rb;
            in_valid = rv;
            #2;
            check("rnd_comb", 32'(out_byte), 32'(inv_ref[rb]));
            @(posedge clk);
            #1;
            exp_v = rv;
            if (rv) exp_b = inv_ref[rb];
            check("rnd_valid", 32'(out_valid_q), 32'(exp_v));
            check("rnd_byte", 32'(out_byte_q), 32'(exp_b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
